button_conditioner: RTL

- Upstream input-conditioning stage for binary_game.
- Takes four raw push-button levels and produces per-button outputs for the game FSM:
  - synchronized, debounced levels;
  - single-clock press enables;
  - auto-repeat enables.
- scen drives Select/Quit; mcen drives selectRight/selectLeft so held arrows scroll the menu.
- Four identical, independent channels share one clock and reset.

---
 rtl/button_conditioner_if.sv | 18 +
 rtl/button_conditioner.sv | 117 +++++++++++
 2 files changed

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - button bundle between raw inputs and conditioned outputs
// Purpose: groups the four raw button levels with their conditioned outputs.
// Signals:
//   btn_in [3:0]  raw asynchronous button levels (bit0 Select, bit1 Quit,
//                 bit2 selectRight, bit3 selectLeft)
//   db     [3:0]  debounced level per channel
//   scen   [3:0]  single-clock enable, one pulse per accepted press
//   mcen   [3:0]  multi-clock enable, press pulse plus auto-repeat pulses
// Modports: master drives btn_in and observes outputs; slave is the conditioner.
interface button_conditioner_if;
  logic [3:0] btn_in;
  logic [3:0] db;
  logic [3:0] scen;
  logic [3:0] mcen;

  modport master (output btn_in, input db, input scen, input mcen);
  modport slave  (input btn_in, output db, output scen, output mcen);
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - four-channel button synchronizer, debouncer and auto-repeat
// Purpose: conditions four raw buttons for the game FSM. Each channel has a
//   2-flop synchronizer feeding a Moore FSM that debounces press and release,
//   emits a single press pulse (scen) and a repeating pulse (mcen) while held.
// Ports:
//   Clk    system clock, rising edge
//   Reset  synchronous active-high reset, overrides everything
//   btnIf  button_conditioner_if.slave (btn_in in; db/scen/mcen out)
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  button_conditioner_if.slave  btnIf
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WQ   = 3'd1,
    SCEN = 3'd2,
    HOLD = 3'd3,
    MCEN = 3'd4,
    WR   = 3'd5
  } stateT;

  logic [3:0]       s1;
  logic [3:0]       s2;
  stateT            state     [4];
  stateT            nextState [4];
  logic [CNT_W-1:0] cnt       [4];
  logic [CNT_W-1:0] nextCnt   [4];
  logic [3:0]       dbR;
  logic [3:0]       scenR;
  logic [3:0]       mcenR;

  // State register, counters and synchronizer.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1 <= '0;
      s2 <= '0;
      for (int i = 0; i < 4; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      s1 <= btnIf.btn_in;
      s2 <= s1;
      for (int i = 0; i < 4; i++) begin
        state[i] <= nextState[i];
        cnt[i]   <= nextCnt[i];
      end
    end
  end

  // Next-state logic. The counter only advances while waiting, and every
  // terminal count forces a state change, so it can never wrap.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      nextState[i] = state[i];
      nextCnt[i]   = '0;
      case (state[i])
        IDLE: begin
          if (s2[i]) nextState[i] = WQ;
        end
        WQ: begin
          if (!s2[i])                nextState[i] = IDLE;
          else if (cnt[i] == DB_LAST) nextState[i] = SCEN;
          else                       nextCnt[i]   = cnt[i] + CNT_W'(1);
        end
        SCEN: begin
          // Input is ignored for this one cycle; the press is already accepted.
          nextState[i] = HOLD;
        end
        HOLD: begin
          if (!s2[i])                nextState[i] = WR;
          else if (cnt[i] == RP_LAST) nextState[i] = MCEN;
          else                       nextCnt[i]   = cnt[i] + CNT_W'(1);
        end
        MCEN: begin
          nextState[i] = s2[i] ? HOLD : WR;
        end
        WR: begin
          // A high sample during release debounce restarts the repeat interval.
          if (s2[i])                 nextState[i] = HOLD;
          else if (cnt[i] == DB_LAST) nextState[i] = IDLE;
          else                       nextCnt[i]   = cnt[i] + CNT_W'(1);
        end
        default: nextState[i] = IDLE;
      endcase
    end
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    dbR   = '0;
    scenR = '0;
    mcenR = '0;
    for (int i = 0; i < 4; i++) begin
      dbR[i]   = (state[i] == SCEN) || (state[i] == HOLD) ||
                 (state[i] == MCEN) || (state[i] == WR);
      scenR[i] = (state[i] == SCEN);
      mcenR[i] = (state[i] == SCEN) || (state[i] == MCEN);
    end
  end

  assign btnIf.db   = dbR;
  assign btnIf.scen = scenR;
  assign btnIf.mcen = mcenR;

endmodule
